// File: rtl/hex_disp_pkg.sv
// Shared constants, state encoding and index helpers for the six-digit HEX
// scroller and its prescaler.
package hex_disp_pkg;

  localparam int HEX_DIGITS = 6;
  localparam int BUF_DEPTH  = 16;

  localparam logic [HEX_DIGITS-1:0] BLANK_ALL = 6'b111111;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SHOW   = 2'd1;
  localparam state_t SCROLL = 2'd2;

  // Lengths above the buffer depth are treated as a full buffer.
  function automatic logic [4:0] clamp_len(input logic [4:0] v);
    return (v > 5'(BUF_DEPTH)) ? 5'(BUF_DEPTH) : v;
  endfunction

  // (pos + k) mod len with a single conditional subtract. The result is in range
  // because pos < len and k < len whenever the index is actually displayed.
  function automatic logic [3:0] win_index(input logic [3:0] p, input int k,
                                           input logic [4:0] len);
    logic [4:0] sum;
    sum = {1'b0, p} + 5'(k);
    return (sum >= len) ? 4'(sum - len) : sum[3:0];
  endfunction

endpackage

// File: rtl/hex_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every DIV clocks; clr
// restarts the count so the first step after a restart is a full period away.
module hex_tick_gen #(
  parameter int DIV = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Six-digit HEX window over a 16-nibble buffer: static for short messages,
// left-scrolling at a prescaled rate for long ones, with per-digit blanking.
module hex_scroll_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DIGITS = HEX_DIGITS,
  parameter int DEPTH  = BUF_DEPTH,
  parameter int DIV    = 12500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  len_we,
  input  logic [4:0]            len_in,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic [3:0]            pos,
  output logic                  wrap_pulse,
  output logic [4*DIGITS-1:0]   digit_out,
  output logic [DIGITS-1:0]     blank_out
);

  state_t              state;
  logic [4:0]          len;
  logic [3:0]          mem [DEPTH];
  logic                tick;
  logic                go;
  logic                scroll_entry;
  logic [4:0]          pos_inc;
  logic [3:0]          idx [DIGITS];
  logic [4*DIGITS-1:0] nxt_digit;
  logic [DIGITS-1:0]   nxt_blank;

  // A simultaneous stop always wins over start.
  assign go           = start && !stop;
  assign scroll_entry = (state == IDLE) && go && (len > 5'(DIGITS));
  assign pos_inc      = {1'b0, pos} + 5'd1;

  hex_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scroll_entry),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      pos        <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (len_we) len <= clamp_len(len_in);
          if (go && len != '0) begin
            state <= (len > 5'(DIGITS)) ? SCROLL : SHOW;
            pos   <= '0;
          end
        end
        SHOW, SCROLL: begin
          if (stop) begin
            state <= IDLE;
            pos   <= '0;
          end else if (state == SCROLL && tick) begin
            if (pos_inc == len) begin
              pos        <= '0;
              wrap_pulse <= 1'b1;
            end else begin
              pos <= pos_inc[3:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the buffer is small enough to live in flops, so it is cleared on
  // reset; a RAM-based buffer would instead be left without a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) idx[k] = win_index(pos, k, len);
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is
  // inferred.
  always_comb begin
    nxt_digit = '0;
    nxt_blank = BLANK_ALL;
    for (int k = 0; k < DIGITS; k++) begin
      if ((state == SCROLL) || (state == SHOW && 5'(k) < len)) begin
        nxt_digit[4*(DIGITS-1-k) +: 4] = mem[idx[k]];
        nxt_blank[DIGITS-1-k]          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out <= '0;
      blank_out <= BLANK_ALL;
      busy      <= 1'b0;
    end else begin
      digit_out <= nxt_digit;
      blank_out <= nxt_blank;
      busy      <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with DIV=4: static show, scroll/wrap
// table, control corner cases, live write, length clamp and async reset.
module tb_hex_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        len_we;
  logic [4:0]  len_in;
  logic        start;
  logic        stop;
  logic        busy;
  logic [3:0]  pos;
  logic        wrap_pulse;
  logic [23:0] digit_out;
  logic [5:0]  blank_out;

  int n_checks = 0;
  int n_fail   = 0;

  hex_scroll_ctrl #(.DIGITS(6), .DEPTH(16), .DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .len_we     (len_we),
    .len_in     (len_in),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .pos        (pos),
    .wrap_pulse (wrap_pulse),
    .digit_out  (digit_out),
    .blank_out  (blank_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          steps;
    logic [23:0] digit;
    logic [5:0]  blank;
    logic        busy;
    logic [3:0]  pos;
    logic        wrap;
  } vec_t;

  vec_t scroll_tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_nib(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_len(input logic [4:0] v);
    len_we = 1'b1; len_in = v;
    step();
    len_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, " busy"},  32'(busy),      32'd0);
    check({tag, " blank"}, 32'(blank_out), 32'h3f);
    check({tag, " digit"}, 32'(digit_out), 32'h0);
    check({tag, " pos"},   32'(pos),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    int wraps;

    // Scroll of buf = 0..7, len 8, starting right after the start edge.
    scroll_tbl[0]  = '{1, 24'h012345, 6'b000000, 1'b1, 4'd0, 1'b0};
    scroll_tbl[1]  = '{3, 24'h012345, 6'b000000, 1'b1, 4'd1, 1'b0};
    scroll_tbl[2]  = '{1, 24'h123456, 6'b000000, 1'b1, 4'd1, 1'b0};
    scroll_tbl[3]  = '{4, 24'h234567, 6'b000000, 1'b1, 4'd2, 1'b0};
    scroll_tbl[4]  = '{4, 24'h345670, 6'b000000, 1'b1, 4'd3, 1'b0};
    scroll_tbl[5]  = '{4, 24'h456701, 6'b000000, 1'b1, 4'd4, 1'b0};
    scroll_tbl[6]  = '{4, 24'h567012, 6'b000000, 1'b1, 4'd5, 1'b0};
    scroll_tbl[7]  = '{4, 24'h670123, 6'b000000, 1'b1, 4'd6, 1'b0};
    scroll_tbl[8]  = '{4, 24'h701234, 6'b000000, 1'b1, 4'd7, 1'b0};
    scroll_tbl[9]  = '{3, 24'h701234, 6'b000000, 1'b1, 4'd0, 1'b1};
    scroll_tbl[10] = '{1, 24'h012345, 6'b000000, 1'b1, 4'd0, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len_we = 1'b0; len_in = '0; start = 1'b0; stop = 1'b0;
    step(2);
    check_idle_outs("por");
    check("por wrap", 32'(wrap_pulse), 32'd0);
    rst_n = 1'b1;
    step();

    // Static show of ABC.
    write_nib(4'd0, 4'hA);
    write_nib(4'd1, 4'hB);
    write_nib(4'd2, 4'hC);
    load_len(5'd3);
    pulse_start();
    step();
    check("show digit", 32'(digit_out), 32'hABC000);
    check("show blank", 32'(blank_out), 32'b000111);
    check("show busy",  32'(busy),      32'd1);
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pos != 4'd0) nz++;
    end
    check("show pos held at 0", 32'(nz), 32'd0);
    pulse_stop();
    step();
    check_idle_outs("show stop");

    // Scroll and wrap, table-driven.
    for (int i = 0; i < 8; i++) write_nib(4'(i), 4'(i));
    load_len(5'd8);
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      step(scroll_tbl[i].steps);
      check($sformatf("scroll[%0d] digit", i), 32'(digit_out),  32'(scroll_tbl[i].digit));
      check($sformatf("scroll[%0d] blank", i), 32'(blank_out),  32'(scroll_tbl[i].blank));
      check($sformatf("scroll[%0d] busy",  i), 32'(busy),       32'(scroll_tbl[i].busy));
      check($sformatf("scroll[%0d] pos",   i), 32'(pos),        32'(scroll_tbl[i].pos));
      check($sformatf("scroll[%0d] wrap",  i), 32'(wrap_pulse), 32'(scroll_tbl[i].wrap));
    end
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (wrap_pulse) wraps++;
    end
    check("wrap pulses per period", 32'(wraps), 32'd1);
    check("wrap digit again", 32'(digit_out), 32'h012345);

    // len_we while busy is ignored; start+stop together returns to IDLE.
    load_len(5'd3);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    check_idle_outs("start+stop");
    pulse_start();
    step();
    check("len kept blank", 32'(blank_out), 32'h00);
    check("len kept digit", 32'(digit_out), 32'h012345);
    check("restart busy",   32'(busy),      32'd1);
    check("restart pos",    32'(pos),       32'd0);

    // Live write during scroll at pos 0.
    write_nib(4'd2, 4'hF);
    step();
    check("live digit[15:12]", 32'(digit_out[15:12]), 32'hF);
    check("live digit",        32'(digit_out),        32'h01F345);
    check("live pos still 0",  32'(pos),              32'd0);
    step();
    check("live cadence pos",  32'(pos),              32'd1);
    step();
    check("live step digit",   32'(digit_out),        32'h1F3456);
    step(4);
    check("live pos 2",        32'(pos),              32'd2);
    check("live pos 2 digit",  32'(digit_out),        32'hF34567);

    // Length clamp: 20 loads as 16, so the wrap comes after 16 steps.
    pulse_stop();
    step();
    load_len(5'd20);
    pulse_start();
    step();
    check("clamp first digit", 32'(digit_out), 32'h01F345);
    step(56);
    check("clamp pos 14",       32'(pos),       32'd14);
    check("clamp pos 14 digit", 32'(digit_out), 32'h0001F3);
    step(6);
    check("clamp pos 15",       32'(pos),       32'd15);
    check("clamp pos 15 digit", 32'(digit_out), 32'h001F34);
    check("clamp no early wrap", 32'(wrap_pulse), 32'd0);
    step();
    check("clamp wrap pos",   32'(pos),        32'd0);
    check("clamp wrap pulse", 32'(wrap_pulse), 32'd1);

    // Start with len 0 does nothing.
    pulse_stop();
    step();
    load_len(5'd0);
    pulse_start();
    step(2);
    check_idle_outs("len0 start");

    // Asynchronous reset in the middle of a scroll.
    load_len(5'd8);
    pulse_start();
    step(5);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outs("async reset");
    check("async reset wrap", 32'(wrap_pulse), 32'd0);
    #1 rst_n = 1'b1;
    step();
    pulse_start();
    step(2);
    check("reset lost len busy", 32'(busy), 32'd0);
    load_len(5'd3);
    pulse_start();
    step();
    check("reset lost buf digit", 32'(digit_out), 32'h000000);
    check("reset lost buf blank", 32'(blank_out), 32'b000111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
